// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ez8 execute sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StExec,
    StWrite
  } seq_state_e;

  // Instruction word field positions.
  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned SEL_HI = 11;
  localparam int unsigned SEL_LO = 9;
  localparam int unsigned DIR    = 8;
  localparam int unsigned OPD_HI = 7;
  localparam int unsigned OPD_LO = 0;

  localparam logic [3:0] OP_GET   = 4'h0;
  localparam logic [3:0] OP_SHIFT = 4'h1;
  localparam logic [3:0] OP_ARITH = 4'h2;
  localparam logic [3:0] OP_LOGIC = 4'h3;
  localparam logic [3:0] OP_SET   = 4'h4;
  localparam logic [3:0] OP_MISC  = 4'hF;

  // Register-class ops take their operand from the register file.
  function automatic logic is_reg_class(input logic [3:0] opc);
    return !opc[2] || (opc == OP_MISC);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, register-file port and architectural state outputs.
interface alu_sequencer_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        reg_req;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_gnt;
  logic [7:0]  reg_rdata;
  logic [7:0]  accum_out;
  logic        z_flag;
  logic        c_flag;
  logic        done;
  logic        err;

  modport slave (
    input  instr, instr_valid, reg_gnt, reg_rdata,
    output instr_ready, reg_req, reg_we, reg_addr, reg_wdata,
           accum_out, z_flag, c_flag, done, err
  );

  modport master (
    output instr, instr_valid, reg_gnt, reg_rdata,
    input  instr_ready, reg_req, reg_we, reg_addr, reg_wdata,
           accum_out, z_flag, c_flag, done, err
  );
endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational ez8 ALU: computes result, flags and write enables for one op.
module alu
  import alu_seq_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [2:0] selector_i,
  input  logic       direction_i,
  input  logic [7:0] operand_i,
  input  logic [7:0] regvalue_i,
  input  logic [7:0] accum_i,
  input  logic       cin_i,
  output logic [7:0] result_o,
  output logic       zout_o,
  output logic       cout_o,
  output logic       accum_write_o,
  output logic       reg_write_o,
  output logic       z_write_o,
  output logic       c_write_o
);

  logic [7:0] val;
  logic [8:0] sum;
  logic       use_dir;

  // Decode op; direction=0 targets ACC, direction=1 targets the register.
  always_comb begin
    val           = is_reg_class(opcode_i) ? regvalue_i : operand_i;
    sum           = 9'd0;
    use_dir       = 1'b0;
    accum_write_o = 1'b0;
    reg_write_o   = 1'b0;
    z_write_o     = 1'b0;
    c_write_o     = 1'b0;
    if (opcode_i == OP_MISC) begin
      use_dir   = 1'b1;
      z_write_o = 1'b1;
      c_write_o = 1'b1;
      case (selector_i)
        3'd0:    sum = {1'b0, val} + 9'd1;
        3'd1:    sum = {1'b0, val} + 9'h0ff;
        default: sum = 9'd0;
      endcase
    end else if (!opcode_i[3]) begin
      case ({2'b00, opcode_i[1:0]})
        OP_GET: begin
          // LD copies the value into ACC; PUT stores ACC to the register.
          if (direction_i) begin
            sum         = {1'b0, accum_i};
            reg_write_o = 1'b1;
          end else begin
            sum           = {1'b0, val};
            accum_write_o = 1'b1;
            z_write_o     = 1'b1;
          end
        end
        OP_SHIFT: begin
          use_dir   = 1'b1;
          z_write_o = 1'b1;
          c_write_o = 1'b1;
          case (selector_i)
            3'd1:    sum = {val[0], 1'b0, val[7:1]};
            3'd2:    sum = {val, cin_i};
            3'd3:    sum = {val[0], cin_i, val[7:1]};
            default: sum = {val, 1'b0};
          endcase
        end
        OP_ARITH: begin
          use_dir   = 1'b1;
          z_write_o = 1'b1;
          c_write_o = 1'b1;
          case (selector_i)
            3'd1:    sum = {1'b0, accum_i} + {1'b0, ~val} + 9'd1;
            3'd2:    sum = {1'b0, accum_i} + {1'b0, val} + {8'd0, cin_i};
            3'd3:    sum = {1'b0, accum_i} + {1'b0, ~val} + {8'd0, cin_i};
            default: sum = {1'b0, accum_i} + {1'b0, val};
          endcase
        end
        default: begin
          use_dir   = 1'b1;
          z_write_o = 1'b1;
          case (selector_i)
            3'd1:    sum = {1'b0, accum_i | val};
            3'd2:    sum = {1'b0, accum_i ^ val};
            3'd3:    sum = {1'b0, ~val};
            default: sum = {1'b0, accum_i & val};
          endcase
        end
      endcase
    end
    if (use_dir) begin
      accum_write_o = !direction_i;
      reg_write_o   = direction_i;
    end
    result_o = sum[7:0];
    cout_o   = sum[8];
    zout_o   = (sum[7:0] == 8'd0);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller: fetches register operands, drives the ALU and
// commits ACC, Z/C and register write-backs.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [7:0] ACC_RESET = 8'h00
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  seq_state_e  state_q;
  logic [15:0] ir_q;
  logic [7:0]  regv_q, acc_q, wdata_q, addr_q;
  logic        z_q, c_q, req_q, we_q, done_q, err_q, ready_q;

  logic [7:0] alu_result, alu_regvalue;
  logic       alu_zout, alu_cout, alu_acc_we, alu_reg_we, alu_z_we, alu_c_we;
  logic       ir_reg_class;

  assign ir_reg_class = is_reg_class(ir_q[OPC_HI:OPC_LO]);
  // Literal-class ops must not see a stale register value.
  assign alu_regvalue = ir_reg_class ? regv_q : 8'd0;

  alu u_alu (
    .opcode_i      (ir_q[OPC_HI:OPC_LO]),
    .selector_i    (ir_q[SEL_HI:SEL_LO]),
    .direction_i   (ir_q[DIR]),
    .operand_i     (ir_q[OPD_HI:OPD_LO]),
    .regvalue_i    (alu_regvalue),
    .accum_i       (acc_q),
    .cin_i         (c_q),
    .result_o      (alu_result),
    .zout_o        (alu_zout),
    .cout_o        (alu_cout),
    .accum_write_o (alu_acc_we),
    .reg_write_o   (alu_reg_we),
    .z_write_o     (alu_z_we),
    .c_write_o     (alu_c_we)
  );

  // Sequencer FSM with registered handshake and register-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= 16'd0;
      regv_q  <= 8'd0;
      acc_q   <= ACC_RESET;
      wdata_q <= 8'd0;
      addr_q  <= 8'd0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.instr_valid && ready_q) begin
            ir_q    <= bus.instr;
            ready_q <= 1'b0;
            if (is_reg_class(bus.instr[OPC_HI:OPC_LO])) begin
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= bus.instr[OPD_HI:OPD_LO];
              state_q <= StRead;
            end else begin
              state_q <= StExec;
            end
          end
        end
        StRead: begin
          if (bus.reg_gnt) begin
            req_q   <= 1'b0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          regv_q  <= bus.reg_rdata;
          state_q <= StExec;
        end
        StExec: begin
          if (alu_acc_we) acc_q <= alu_result;
          if (alu_z_we)   z_q   <= alu_zout;
          if (alu_c_we)   c_q   <= alu_cout;
          if (alu_reg_we && ir_reg_class) begin
            wdata_q <= alu_result;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= StWrite;
          end else begin
            // A register write from a literal op has no address to go to.
            err_q   <= alu_reg_we;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        StWrite: begin
          if (bus.reg_gnt) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.reg_req     = req_q;
  assign bus.reg_we      = we_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.accum_out   = acc_q;
  assign bus.z_flag      = z_q;
  assign bus.c_flag      = c_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small register-file/arbiter model.
module tb_alu_sequencer;

  logic clk;
  logic reset;
  alu_sequencer_if bus ();

  alu_sequencer #(.ACC_RESET(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Arbiter settings, written only by the stimulus block.
  int gnt_delay = 0;
  bit tie_gnt   = 1'b0;

  // Register-file model state, written only by the model block.
  logic [7:0] mem [256];
  bit         mem_init   = 1'b0;
  int         wait_cnt   = 0;
  bit         prev_denied = 1'b0;
  logic [7:0] s_addr, s_wdata;
  logic       s_we;
  int         req_cycles = 0;
  int         unstable   = 0;
  int         writes     = 0;
  logic [7:0] last_raddr = 8'hxx;
  logic [7:0] last_waddr = 8'hxx;
  logic [7:0] last_wdata = 8'hxx;

  // Register file plus arbiter: grants after gnt_delay denied cycles per request.
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = i[7:0];
      mem_init = 1'b1;
    end
    if (bus.reg_req === 1'b1) begin
      req_cycles++;
      if (prev_denied && (bus.reg_addr !== s_addr || bus.reg_we !== s_we ||
                          bus.reg_wdata !== s_wdata)) unstable++;
      if (wait_cnt < gnt_delay) begin
        bus.reg_gnt = 1'b0;
        wait_cnt++;
      end else begin
        bus.reg_gnt = 1'b1;
      end
      if (bus.reg_gnt) begin
        if (bus.reg_we) begin
          mem[bus.reg_addr] = bus.reg_wdata;
          last_waddr = bus.reg_addr;
          last_wdata = bus.reg_wdata;
          writes++;
        end else begin
          bus.reg_rdata = mem[bus.reg_addr];
          last_raddr = bus.reg_addr;
        end
      end
      prev_denied = !bus.reg_gnt;
      s_addr  = bus.reg_addr;
      s_we    = bus.reg_we;
      s_wdata = bus.reg_wdata;
    end else begin
      bus.reg_gnt = tie_gnt;
      wait_cnt    = 0;
      prev_denied = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction at the next negedge; it is taken at the following posedge.
  task automatic issue(input logic [15:0] w, input bit hold);
    @(negedge clk);
    check("ready_before_issue", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.instr_valid = 1'b0;
  endtask

  // Count edges from the handshake edge until done is seen; 999 on timeout.
  task automatic wait_done(output int lat, output logic err_seen, output int ready_hi);
    bit got = 1'b0;
    lat      = 0;
    ready_hi = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      got = bus.done;
      if (!got && bus.instr_ready) ready_hi++;
    end
    if (!got) lat = 999;
    err_seen = bus.err;
  endtask

  initial begin
    int   lat, rdy_hi, req0, unst0, wr0;
    logic e;

    // Reset with random inputs.
    reset           = 1'b1;
    bus.instr       = 16'($urandom);
    bus.instr_valid = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_accum", {24'd0, bus.accum_out}, 32'h00);
    check("rst_z", {31'd0, bus.z_flag}, 32'd0);
    check("rst_c", {31'd0, bus.c_flag}, 32'd0);
    check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("rst_req", {31'd0, bus.reg_req}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    reset           = 1'b0;

    // Reset while a read request is pending and ungranted.
    gnt_delay = 100;
    tie_gnt   = 1'b0;
    issue(16'h0005, 1'b0);
    check("rdrst_req", {31'd0, bus.reg_req}, 32'd1);
    check("rdrst_addr", {24'd0, bus.reg_addr}, 32'h05);
    check("rdrst_we", {31'd0, bus.reg_we}, 32'd0);
    check("rdrst_ready_low", {31'd0, bus.instr_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rdrst_req_held", {31'd0, bus.reg_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rdrst_req_async", {31'd0, bus.reg_req}, 32'd0);
    check("rdrst_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("rdrst_accum", {24'd0, bus.accum_out}, 32'h00);
    check("rdrst_zc", {30'd0, bus.z_flag, bus.c_flag}, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    gnt_delay = 0;

    // Literal sequence: SET 228, ADDL 28.
    req0 = req_cycles;
    issue(16'h40E4, 1'b0);
    wait_done(lat, e, rdy_hi);
    check("set_lat", lat, 1);
    check("set_acc", {24'd0, bus.accum_out}, 32'd228);
    check("set_z", {31'd0, bus.z_flag}, 32'd0);
    issue(16'h601C, 1'b0);
    wait_done(lat, e, rdy_hi);
    check("addl_lat", lat, 1);
    check("addl_acc", {24'd0, bus.accum_out}, 32'd0);
    check("addl_zc", {30'd0, bus.z_flag, bus.c_flag}, 32'b11);
    check("addl_err", {31'd0, e}, 32'd0);
    check("lit_no_req", req_cycles - req0, 0);

    // ADC reg 10 with ACC=228, C=1, grant tied high.
    tie_gnt = 1'b1;
    issue(16'h40E4, 1'b0);
    wait_done(lat, e, rdy_hi);
    check("set2_acc_c", {23'd0, bus.accum_out, bus.c_flag}, {23'd0, 8'd228, 1'b1});
    issue(16'h240A, 1'b0);
    wait_done(lat, e, rdy_hi);
    check("adc_lat", lat, 3);
    check("adc_raddr", {24'd0, last_raddr}, 32'd10);
    check("adc_acc", {24'd0, bus.accum_out}, 32'd239);
    check("adc_zc", {30'd0, bus.z_flag, bus.c_flag}, 32'b00);
    check("adc_ready_low", rdy_hi, 0);

    // PUT reg 0x20 with one denied grant cycle on both read and write.
    issue(16'h400A, 1'b0);
    wait_done(lat, e, rdy_hi);
    tie_gnt   = 1'b0;
    gnt_delay = 1;
    unst0     = unstable;
    wr0       = writes;
    issue(16'h0120, 1'b0);
    wait_done(lat, e, rdy_hi);
    check("put_lat", lat, 6);
    check("put_writes", writes - wr0, 1);
    check("put_waddr", {24'd0, last_waddr}, 32'h20);
    check("put_wdata", {24'd0, last_wdata}, 32'h0A);
    check("put_mem", {24'd0, mem[8'h20]}, 32'h0A);
    check("put_stable", unstable - unst0, 0);
    check("put_acc", {24'd0, bus.accum_out}, 32'h0A);
    check("put_req_low", {31'd0, bus.reg_req}, 32'd0);

    // Busy: valid held through LD reg 0x33, then SLLL dir=1 follows.
    gnt_delay = 0;
    tie_gnt   = 1'b1;
    issue(16'h0033, 1'b1);
    bus.instr = 16'h5103;
    wait_done(lat, e, rdy_hi);
    check("busy_lat", lat, 3);
    check("busy_ready_low", rdy_hi, 0);
    check("busy_ready_at_done", {31'd0, bus.instr_ready}, 32'd1);
    check("busy_err0", {31'd0, e}, 32'd0);
    check("busy_acc", {24'd0, bus.accum_out}, 32'h33);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    req0 = req_cycles;
    check("slll_taken", {31'd0, bus.instr_ready}, 32'd0);
    wait_done(lat, e, rdy_hi);
    check("slll_lat", lat, 1);
    check("slll_err", {31'd0, e}, 32'd1);
    check("slll_no_req", req_cycles - req0, 0);
    check("slll_acc", {24'd0, bus.accum_out}, 32'h33);
    check("slll_zc", {30'd0, bus.z_flag, bus.c_flag}, 32'b00);
    @(posedge clk);
    #1;
    check("err_pulse", {31'd0, bus.err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
